// File: rtl/zap_thumb_halfword_aligner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : zap_thumb_halfword_aligner                                   |
// | Description : Feeds the Thumb decoder. Registers 32-bit fetch words out as |
// |               instructions. In ARM state each word is one instruction. In  |
// |               Thumb state each word is split into one or two 16-bit        |
// |               halfwords, each with its own PC. Fetch is back-pressured     |
// |               while the second halfword of a word is still pending.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   BIG_END   0: halfword at PC[1]=0 is word[15:0]; 1: it is word[31:16]     |
// | Ports                                                                      |
// |   i_clk                in   1  clock                                       |
// |   i_reset_n            in   1  synchronous active-low reset                |
// |   i_clear              in   1  pipeline flush, drops all state             |
// |   i_stall              in   1  downstream stall, output registers hold     |
// |   i_cpsr_ff_t          in   1  T bit, sampled when a word is accepted      |
// |   i_word               in  32  fetched word                               |
// |   i_word_valid         in   1  qualifies i_word / i_word_pc / i_iabort     |
// |   i_word_pc            in  32  byte address of the fetch                  |
// |   i_iabort             in   1  instruction abort on this fetch            |
// |   o_ready              out  1  word accepted when o_ready & i_word_valid  |
// |   o_instruction        out 32  ARM word, or Thumb halfword zero-extended  |
// |   o_instruction_valid  out  1  o_instruction qualifier                    |
// |   o_pc_ff              out 32  address of o_instruction                   |
// |   o_pc_plus_8_ff       out 32  o_pc_ff+8 (ARM) or o_pc_ff+4 (Thumb)       |
// |   o_iabort             out  1  abort flag for o_instruction               |
// +----------------------------------------------------------------------------+

module zap_thumb_halfword_aligner #(
   parameter bit BIG_END = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_clear,
   input  logic        i_stall,
   input  logic        i_cpsr_ff_t,
   input  logic [31:0] i_word,
   input  logic        i_word_valid,
   input  logic [31:0] i_word_pc,
   input  logic        i_iabort,
   output logic        o_ready,
   output logic [31:0] o_instruction,
   output logic        o_instruction_valid,
   output logic [31:0] o_pc_ff,
   output logic [31:0] o_pc_plus_8_ff,
   output logic        o_iabort
);

   // IDLE   : nothing buffered, a new word may be accepted.
   // SECOND : the second Thumb halfword of the last word is buffered.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      SECOND = 1'b1
   } state_t;

   localparam logic [31:0] ARM_PC_STEP   = 32'd8;
   localparam logic [31:0] THUMB_PC_STEP = 32'd4;
   localparam logic [31:0] HALF_STEP     = 32'd2;

   state_t      state;
   logic [15:0] buf_half;   // pending second halfword
   logic [31:0] buf_pc;     // address of the pending halfword

   logic [15:0] half_even;  // halfword living at PC[1]=0
   logic [15:0] half_odd;   // halfword living at PC[1]=1
   logic        accept;

   // Byte-lane selection depends only on endianness; the address bit picks
   // which of the two is issued first.
   assign half_even = BIG_END ? i_word[31:16] : i_word[15:0];
   assign half_odd  = BIG_END ? i_word[15:0]  : i_word[31:16];

   assign o_ready = i_reset_n & ~i_clear & ~i_stall & (state == IDLE);
   assign accept  = o_ready & i_word_valid;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state               <= IDLE;
         buf_half            <= 16'h0000;
         buf_pc              <= 32'h0000_0000;
         o_instruction       <= 32'h0000_0000;
         o_instruction_valid <= 1'b0;
         o_pc_ff             <= 32'h0000_0000;
         o_pc_plus_8_ff      <= 32'h0000_0000;
         o_iabort            <= 1'b0;
      end else if (i_clear) begin
         // Flush: the buffered halfword is abandoned, PCs are left as-is.
         state               <= IDLE;
         o_instruction_valid <= 1'b0;
         o_iabort            <= 1'b0;
      end else if (i_stall) begin
         // Everything holds.
      end else if (state == SECOND) begin
         // Issue the buffered halfword; o_ready is low so no word is taken.
         state               <= IDLE;
         o_instruction       <= {16'h0000, buf_half};
         o_instruction_valid <= 1'b1;
         o_pc_ff             <= buf_pc;
         o_pc_plus_8_ff      <= buf_pc + THUMB_PC_STEP;
         o_iabort            <= 1'b0;
      end else if (accept) begin
         o_instruction_valid <= 1'b1;
         o_pc_ff             <= i_word_pc;
         o_iabort            <= i_iabort;
         if (!i_cpsr_ff_t) begin
            o_instruction  <= i_word;
            o_pc_plus_8_ff <= i_word_pc + ARM_PC_STEP;
         end else if (i_word_pc[1]) begin
            // Branch into the odd halfword: only that halfword is valid.
            o_instruction  <= {16'h0000, half_odd};
            o_pc_plus_8_ff <= i_word_pc + THUMB_PC_STEP;
         end else begin
            o_instruction  <= {16'h0000, half_even};
            o_pc_plus_8_ff <= i_word_pc + THUMB_PC_STEP;
            // An aborted fetch yields a single (aborting) instruction; its
            // second halfword is meaningless and is not buffered.
            if (!i_iabort) begin
               state    <= SECOND;
               buf_half <= half_odd;
               buf_pc   <= i_word_pc + HALF_STEP;
            end
         end
      end else begin
         o_instruction_valid <= 1'b0;
      end
   end

endmodule

`default_nettype wire
